// File: rtl/shreg_piso_universal_if.sv
// ============================================================================
// Module      : shreg_piso_universal_if
// Description : Control/data bundle for the universal shift register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shreg_piso_universal_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic                 shclk;
    logic                 inh;
    logic [1:0]           mode;
    logic                 ser_l;
    logic                 ser_r;
    logic [WIDTH-1:0]     pdata;
    logic [WIDTH-1:0]     q;
    logic                 qh;
    logic                 ql;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 empty;
    logic                 op_stb;

    modport master (
        output shclk, inh, mode, ser_l, ser_r, pdata,
        input  q, qh, ql, bit_cnt, empty, op_stb
    );

    modport slave (
        input  shclk, inh, mode, ser_l, ser_r, pdata,
        output q, qh, ql, bit_cnt, empty, op_stb
    );
endinterface

`default_nettype wire

// File: rtl/shreg_piso_universal.sv
// ============================================================================
// Module      : shreg_piso_universal
// Description : Universal shift register (hold/left/right/load) driven by an
//               edge-detected shift clock; optional input synchroniser when
//               SHCLK_SYNC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shreg_piso_universal #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter logic             SHCLK_IDLE = 1'b1
) (
    input  wire                      clk,
    input  wire                      rst,
    shreg_piso_universal_if.slave    bus
);
    localparam int               CNT_W       = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_CNT_FULL  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [1:0]       C_MODE_HOLD = 2'b00;
    localparam logic [1:0]       C_MODE_SHL  = 2'b01;
    localparam logic [1:0]       C_MODE_SHR  = 2'b10;
    localparam logic [1:0]       C_MODE_LOAD = 2'b11;

    logic             w_shclk;
    logic             w_inh;
    logic             w_accept;
    logic             r_prev_shclk;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_op_stb;

`ifdef SHCLK_SYNC_EN
    logic [1:0] r_sync_shclk;
    logic [1:0] r_sync_inh;

    // Both inputs go through identical stages so inh stays aligned with shclk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_shclk <= {2{SHCLK_IDLE}};
            r_sync_inh   <= 2'b00;
        end else begin
            r_sync_shclk <= {r_sync_shclk[0], bus.shclk};
            r_sync_inh   <= {r_sync_inh[0], bus.inh};
        end
    end

    assign w_shclk = r_sync_shclk[1];
    assign w_inh   = r_sync_inh[1];
`else
    assign w_shclk = bus.shclk;
    assign w_inh   = bus.inh;
`endif

    assign w_accept = w_shclk & ~r_prev_shclk & ~w_inh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_shclk <= SHCLK_IDLE;
            r_q          <= RESET_VAL;
            r_bit_cnt    <= C_CNT_FULL;
            r_op_stb     <= 1'b0;
        end else begin
            r_prev_shclk <= w_shclk;
            r_op_stb     <= 1'b0;
            if (w_accept) begin
                case (bus.mode)
                    C_MODE_SHL: begin
                        r_q      <= {r_q[WIDTH-2:0], bus.ser_l};
                        r_op_stb <= 1'b1;
                        if (r_bit_cnt != C_CNT_FULL) r_bit_cnt <= r_bit_cnt + C_CNT_ONE;
                    end
                    C_MODE_SHR: begin
                        r_q      <= {bus.ser_r, r_q[WIDTH-1:1]};
                        r_op_stb <= 1'b1;
                        if (r_bit_cnt != C_CNT_FULL) r_bit_cnt <= r_bit_cnt + C_CNT_ONE;
                    end
                    C_MODE_LOAD: begin
                        r_q       <= bus.pdata;
                        r_bit_cnt <= '0;
                        r_op_stb  <= 1'b1;
                    end
                    C_MODE_HOLD: ;
                    default: ;
                endcase
            end
        end
    end

    assign bus.q       = r_q;
    assign bus.qh      = r_q[WIDTH-1];
    assign bus.ql      = r_q[0];
    assign bus.bit_cnt = r_bit_cnt;
    assign bus.empty   = (r_bit_cnt == C_CNT_FULL);
    assign bus.op_stb  = r_op_stb;

endmodule

`default_nettype wire

// File: doc/shreg_piso_universal.md
Name: shreg_piso_universal

Overview:
- Parametrised, FPGA-friendly universal shift register. Successor to the fixed 8-bit parallel-in/serial-out part.
- Runs entirely on the system clock. The external shift clock is sampled and edge-detected rather than used as a clock.
- Adds four modes (hold, shift left, shift right, parallel load), parallel readback, and a shifted-bit counter with an empty flag, so serialisers and deserialisers can be built without glue logic.

Parameters:
- WIDTH, 8, register width in bits; minimum 2.
- RESET_VAL, 0, value of q after reset; WIDTH bits wide.
- SHCLK_IDLE, 1, reset value of the previous-shclk register; 1 suppresses a spurious edge when shclk is high out of reset.

Ports:
- clk  in  1  system clock; everything is on its rising edge.
- rst  in  1  synchronous reset, active-high.
- shclk  in  1  external shift clock; its rising edge triggers an operation.
- inh  in  1  clock inhibit, active-high; an edge seen while inh=1 is discarded.
- mode  in  2  00 hold, 01 shift left, 10 shift right, 11 parallel load.
- ser_l  in  1  serial input entering at bit 0 on shift left.
- ser_r  in  1  serial input entering at bit WIDTH-1 on shift right.
- pdata  in  WIDTH  parallel load data.
- q  out  WIDTH  register contents.
- qh  out  1  q[WIDTH-1]; the serial output for shift left.
- ql  out  1  q[0]; the serial output for shift right.
- bit_cnt  out  clog2(WIDTH+1)  shifts since the last load, saturating at WIDTH.
- empty  out  1  1 when bit_cnt == WIDTH.
- op_stb  out  1  one-cycle pulse marking that q/bit_cnt were updated.

Behaviour:
- Only clk is a clock. Reset is synchronous, active-high, and has priority over all other inputs.
- Values on reset:
  - q = RESET_VAL.
  - bit_cnt = WIDTH, so empty = 1.
  - op_stb = 0.
  - prev_shclk = SHCLK_IDLE.
- prev_shclk <= shclk on every non-reset cycle. This includes cycles where inh=1.
- Edge detection: edge = shclk & ~prev_shclk. An edge is accepted when edge & ~inh.
  - A rejected edge is lost. It is never deferred or queued.
- mode and the data inputs are sampled in the same cycle the edge is accepted.
- Actions on an accepted edge:
  - 00 hold: no change, op_stb stays 0.
  - 01 shift left: q <= {q[WIDTH-2:0], ser_l}.
  - 10 shift right: q <= {ser_r, q[WIDTH-1:1]}.
  - 11 load: q <= pdata and bit_cnt <= 0.
- On each shift, bit_cnt <= min(bit_cnt+1, WIDTH). Shifting continues when empty=1; only the counter saturates.
- Latency: q, bit_cnt and op_stb are registered. They change on the clk edge where shclk is first sampled high and are visible in the following cycle, all together.
- qh, ql and empty are combinational decodes of the registered state.
- A level-high shclk yields exactly one operation. A new operation requires shclk to be low for at least one clk sample.
- If rst and an accepted edge occur in the same cycle, rst wins. prev_shclk is forced to SHCLK_IDLE, so with SHCLK_IDLE=1 that edge is not re-detected afterwards.
- shclk must be stable for at least one clk period high and one clk period low. Faster toggling is undefined.

Optional Feature:
- SHCLK_SYNC_EN
  - Defined: shclk and inh pass through a 2-flop synchroniser (reset to SHCLK_IDLE and 0) before edge detection. Latency from the shclk rising edge to the q update grows by 2 clk cycles; inh is delayed identically, so their relative alignment is preserved.
  - Not defined: no synchroniser. shclk/inh are assumed synchronous to clk, and behaviour is as above.

Test Plan:
- Reset with shclk=1 (WIDTH=8, RESET_VAL=0), release rst, hold shclk high -> q=0x00, bit_cnt=8, empty=1, no op_stb.
- mode=11, pdata=0xA5, one shclk pulse -> q=0xA5, bit_cnt=0, empty=0, op_stb high for exactly 1 cycle.
- After loading 0xA5, 8 pulses with mode=01, ser_l=1 -> qh sequence 1,0,1,0,0,1,0,1; final q=0xFF; bit_cnt=8; empty=1. A 9th pulse gives q=0xFF with bit_cnt still 8.
- Load 0x81, then 2 pulses with mode=10, ser_r=0 -> q=0x20 and bit_cnt=2 after the second pulse; ql sequence 1,0,0.
- Pulse shclk with inh=1, then a pulse with inh=0 and mode=11, pdata=0x3C -> the first pulse changes nothing; the second loads 0x3C. Also: shclk held high across many clk cycles gives one op only.
- rst asserted in the same cycle as an accepted load edge -> q=RESET_VAL and bit_cnt=8. With SHCLK_SYNC_EN defined, repeat the load test and check q updates 2 cycles later than in the non-sync build.
